// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters
// (CPU load/store unit on port C, host loader on port H) and the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  // Port C: CPU load/store unit
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  // Port H: host loader/dumper
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  // Single-port data memory
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // Requester / memory side
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU
// (port C) and the host loader (port H). Round-robin between the two,
// with a host-priority override. Grants are combinational in the request
// cycle; read data returns one cycle later tagged to the requesting port.
// Also counts CPU stall cycles (request pending but not granted).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             host_prio,
  input  logic             stall_clr,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_H = 1'b1
  } port_t;

  // Arbitration / read-tracking state
  port_t             last_owner;
  port_t             last_owner_nxt;
  logic              rd_pend;
  logic              rd_pend_nxt;
  port_t             rd_tag;
  port_t             rd_tag_nxt;
  logic [CNT_W-1:0]  stall_nxt;

  // Combinational grant and selected command
  logic              c_win;
  logic              h_win;
  logic              granted;
  port_t             win_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the winner for this cycle; nothing is granted while in reset
  always_comb begin
    c_win = 1'b0;
    h_win = 1'b0;
    if (rst_n) begin
      if (bus.c_req && bus.h_req) begin
        if (host_prio) begin
          h_win = 1'b1;
        end else if (last_owner == PORT_H) begin
          c_win = 1'b1;
        end else begin
          h_win = 1'b1;
        end
      end else begin
        c_win = bus.c_req;
        h_win = bus.h_req;
      end
    end
  end

  assign granted  = c_win | h_win;
  assign win_port = h_win ? PORT_H : PORT_C;

  // Route the winner's command fields to the memory; C's fields when idle
  always_comb begin
    sel_we    = bus.c_we;
    sel_addr  = bus.c_addr;
    sel_wdata = bus.c_wdata;
    if (h_win) begin
      sel_we    = bus.h_we;
      sel_addr  = bus.h_addr;
      sel_wdata = bus.h_wdata;
    end
  end

  assign bus.c_gnt   = c_win;
  assign bus.h_gnt   = h_win;
  assign bus.m_en    = granted;
  assign bus.m_we    = granted & sel_we;
  assign bus.m_addr  = sel_addr;
  assign bus.m_wdata = sel_wdata;

  // Read response: memory data is passed straight through; only the
  // port whose read was granted last cycle sees rvalid
  always_comb begin
    bus.c_rvalid = rst_n & rd_pend & (rd_tag == PORT_C);
    bus.h_rvalid = rst_n & rd_pend & (rd_tag == PORT_H);
    bus.c_rdata  = bus.m_rdata;
    bus.h_rdata  = bus.m_rdata;
  end

  // Next-state for owner history and outstanding-read tracking
  always_comb begin
    last_owner_nxt = last_owner;
    rd_pend_nxt    = 1'b0;
    rd_tag_nxt     = rd_tag;
    if (granted) begin
      last_owner_nxt = win_port;
      if (!sel_we) begin
        rd_pend_nxt = 1'b1;
        rd_tag_nxt  = win_port;
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= PORT_H;
      rd_pend    <= 1'b0;
      rd_tag     <= PORT_C;
    end else begin
      last_owner <= last_owner_nxt;
      rd_pend    <= rd_pend_nxt;
      rd_tag     <= rd_tag_nxt;
    end
  end

  // Stall counter next value: clear wins, otherwise saturating increment
  always_comb begin
    stall_nxt = stall_cnt;
    if (stall_clr) begin
      stall_nxt = '0;
    end else if (bus.c_req && !c_win && (stall_cnt != '1)) begin
      stall_nxt = stall_cnt + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_nxt;
    end
  end

endmodule
